// File: rtl/signed_or_unsigned_div_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
package signed_or_unsigned_div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/signed_or_unsigned_div_if.sv
// Request/response handshake bundle for signed_or_unsigned_div.
interface signed_or_unsigned_div_if #(parameter int n = 8);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         signed_div;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] quot;
  logic [n-1:0] rem;
  logic         div_by_zero;

  modport master (output in_valid, a, b, signed_div, out_ready,
                  input  in_ready, out_valid, quot, rem, div_by_zero);
  modport slave  (input  in_valid, a, b, signed_div, out_ready,
                  output in_ready, out_valid, quot, rem, div_by_zero);
endinterface

// File: rtl/signed_or_unsigned_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(parameter int n = 8) (
  input  logic [n-1:0] rem,
  input  logic [n-1:0] divisor,
  input  logic         bit_in,
  output logic [n-1:0] rem_next,
  output logic         q_bit
);
  logic [n:0] trial;

  assign trial = {rem, bit_in};
  assign q_bit = (trial >= {1'b0, divisor});
  // When the subtraction is taken the result is below divisor, so n-bit wrap is exact.
  assign rem_next = q_bit ? (trial[n-1:0] - divisor) : trial[n-1:0];
endmodule

// File: rtl/signed_or_unsigned_div.sv
// Multi-cycle signed/unsigned restoring divider, one op in flight, n steps per op.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and responds after one cycle.
module signed_or_unsigned_div
  import signed_or_unsigned_div_pkg::*;
#(
  parameter int n = 8
) (
  input logic                    clk,
  input logic                    rst,
  signed_or_unsigned_div_if.slave bus
);
  localparam int CW = clog2(n);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  dvd, dvs, prem, qacc, a_raw, quot_q, rem_q;
  logic          neg_q, neg_r, zero, in_ready_q, out_valid_q, dz_q;
  logic [n-1:0]  a_mag, b_mag, step_rem, q_mag;
  logic          step_q, is_signed;

  assign is_signed = bus.signed_div;
  assign a_mag = (is_signed && bus.a[n-1]) ? -bus.a : bus.a;
  assign b_mag = (is_signed && bus.b[n-1]) ? -bus.b : bus.b;

  div_step #(.n(n)) u_step (
    .rem(prem), .divisor(dvs), .bit_in(dvd[n-1]),
    .rem_next(step_rem), .q_bit(step_q)
  );

  assign q_mag = {qacc[n-2:0], step_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      qacc        <= '0;
      a_raw       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state      <= BUSY;
          in_ready_q <= 1'b0;
          dvd        <= a_mag;
          dvs        <= b_mag;
          prem       <= '0;
          qacc       <= '0;
          a_raw      <= bus.a;
          neg_q      <= is_signed & (bus.a[n-1] ^ bus.b[n-1]);
          neg_r      <= is_signed & bus.a[n-1];
          zero       <= (bus.b == '0);
`ifdef DIV_ZERO_FAST_EN
          // Zero divisor: a single BUSY cycle finalises, the override fixes the values.
          cnt        <= (bus.b == '0) ? '0 : CW'(n - 1);
`else
          cnt        <= CW'(n - 1);
`endif
        end
        BUSY: begin
          prem <= step_rem;
          qacc <= q_mag;
          dvd  <= {dvd[n-2:0], 1'b0};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            dz_q        <= zero;
            quot_q      <= zero ? '1 : (neg_q ? -q_mag : q_mag);
            rem_q       <= zero ? a_raw : (neg_r ? -step_rem : step_rem);
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule
